// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: TXDATA/STATUS/DIVISOR registers, byte FIFO,
// and an 8N1 serializer whose bit period is latched from DIVISOR at frame start.
module mmio_uart_tx #(
    parameter int unsigned           WIDTH      = 32,
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'hFFFF_FF00,
    parameter int unsigned           CLK_DIV    = 16,
    parameter int unsigned           FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  memread_i,
    input  logic                  memwrite_i,
    input  logic [ADDR_WIDTH-1:0] memaddr_i,
    input  logic [WIDTH-1:0]      memwdata_i,
    output logic [WIDTH-1:0]      memrdata_o,
    output logic                  sel_o,
    output logic                  tx_o
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e          state_q, state_d;
    logic [7:0]      fifo_q [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            ovf_q, ovf_d;
    logic [15:0]     div_q, div_d;
    logic [15:0]     bit_div_q, bit_div_d;
    logic [15:0]     cnt_q, cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;

    logic            hit, wr_en, push, push_ok, pop, full, empty, busy, bit_end;
    logic [1:0]      off;
    logic [4:0]      count_ext;
    logic            unused_bits;

    assign hit       = (memaddr_i[ADDR_WIDTH-1:4] == BASE_ADDR[ADDR_WIDTH-1:4]);
    assign sel_o     = hit;
    assign off       = memaddr_i[3:2];
    assign wr_en     = memwrite_i & hit;
    assign push      = wr_en & (off == 2'd0);
    assign full      = (count_q == CW'(FIFO_DEPTH));
    assign empty     = (count_q == '0);
    assign busy      = (state_q != StIdle);
    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    assign push_ok   = push & (~full | pop);
    assign bit_end   = (cnt_q == bit_div_q - 16'd1);
    assign count_ext = 5'(count_q);
    assign unused_bits = ^{memaddr_i[1:0], memwdata_i[WIDTH-1:16]};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        bit_div_d = bit_div_q;
        pop       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!empty) begin
                    pop       = 1'b1;
                    shift_d   = fifo_q[rd_ptr_q];
                    bit_div_d = div_q;
                    cnt_d     = '0;
                    state_d   = StStart;
                end
            end
            StStart: begin
                if (bit_end) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = StData;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StData: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StStop: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (!empty) begin
                        pop       = 1'b1;
                        shift_d   = fifo_q[rd_ptr_q];
                        bit_div_d = div_q;
                        state_d   = StStart;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        div_d    = div_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)     rd_ptr_d = rd_ptr_q + PW'(1);
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (wr_en && off == 2'd1) begin
            ovf_d = 1'b0;
        end else if (push && !push_ok) begin
            ovf_d = 1'b1;
        end
        if (wr_en && off == 2'd2) begin
            div_d = (memwdata_i[15:0] == 16'd0) ? 16'd1 : memwdata_i[15:0];
        end
    end

    always_comb begin
        memrdata_o = '0;
        if (memread_i && hit) begin
            case (off)
                2'd1:    memrdata_o[8:0]  = {count_ext, ovf_q, busy, empty, full};
                2'd2:    memrdata_o[15:0] = div_q;
                default: memrdata_o       = '0;
            endcase
        end
    end

    always_comb begin
        tx_o = 1'b1;
        case (state_q)
            StStart: tx_o = 1'b0;
            StData:  tx_o = shift_q[bit_idx_q];
            default: tx_o = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_ok) fifo_q[wr_ptr_q] <= memwdata_i[7:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            div_q     <= 16'(CLK_DIV);
            bit_div_q <= 16'(CLK_DIV);
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            div_q     <= div_d;
            bit_div_q <= bit_div_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: bytes pushed are queued with the bit period they should use;
// a line monitor reconstructs every frame sample-by-sample and checks it against the queue.
module tb_mmio_uart_tx;

    localparam int unsigned CLK_DIV = 4;
    localparam int unsigned DEPTH   = 8;
    localparam logic [31:0] BASE    = 32'hFFFF_FF00;

    logic        clk = 1'b0;
    logic        rst;
    logic        memread, memwrite;
    logic [31:0] memaddr, memwdata, memrdata;
    logic        sel, tx;

    typedef struct {
        logic [7:0]  data;
        int unsigned div;
    } frame_t;

    frame_t      exp_q[$];
    int          start_cyc[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int unsigned cur_div;
    bit          mon_busy = 1'b0;

    mmio_uart_tx #(
        .WIDTH      (32),
        .ADDR_WIDTH (32),
        .BASE_ADDR  (BASE),
        .CLK_DIV    (CLK_DIV),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .memread_i  (memread),
        .memwrite_i (memwrite),
        .memaddr_i  (memaddr),
        .memwdata_i (memwdata),
        .memrdata_o (memrdata),
        .sel_o      (sel),
        .tx_o       (tx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic exp_bit(input logic [7:0] b, input int k, input int unsigned div);
        int idx;
        idx = k / int'(div);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
        return 1'b1;
    endfunction

    function automatic logic [31:0] reg_addr(input int off);
        return BASE | (32'(off) << 2) | 32'($urandom_range(0, 3));
    endfunction

    // All bus tasks start and end 1 time unit after a rising edge.
    task automatic bus_wr(input int off, input logic [31:0] data);
        memaddr  = reg_addr(off);
        memwdata = data;
        memwrite = 1'b1;
        @(posedge clk);
        #1;
        memwrite = 1'b0;
        if (off == 2) cur_div = (data[15:0] == 16'd0) ? 1 : int'(data[15:0]);
    endtask

    task automatic bus_rd(input int off, output logic [31:0] data);
        memaddr = reg_addr(off);
        memread = 1'b1;
        #1;
        data    = memrdata;
        memread = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        frame_t f;
        f.data = b;
        f.div  = cur_div;
        exp_q.push_back(f);
        bus_wr(0, {$urandom_range(0, 32'hFF_FFFF), b});
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            if (exp_q.size() == 0 && !mon_busy) begin
                done = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL idle_timeout: %0d frames still pending, expected 0", exp_q.size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        exp_q.delete();
        cur_div = CLK_DIV;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // Line monitor: a falling edge after idle/stop opens a frame of 10*div samples.
    initial begin
        frame_t f;
        logic   prev, bad_act;
        bit     ok, aborted;
        int     bad_k;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (rst && prev && !tx) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_frame: start bit at cycle %0d, no byte pending", cyc);
                end else begin
                    f        = exp_q.pop_front();
                    mon_busy = 1'b1;
                    start_cyc.push_back(cyc);
                    ok       = 1'b1;
                    aborted  = 1'b0;
                    bad_k    = 0;
                    bad_act  = 1'b0;
                    for (int k = 0; k < 10 * int'(f.div); k++) begin
                        if (k > 0) @(negedge clk);
                        if (!rst) begin
                            aborted = 1'b1;
                            break;
                        end
                        if (ok && tx !== exp_bit(f.data, k, f.div)) begin
                            ok      = 1'b0;
                            bad_k   = k;
                            bad_act = tx;
                        end
                    end
                    if (!aborted) begin
                        n_tests++;
                        if (!ok) begin
                            n_fail++;
                            $display("FAIL frame 0x%02h div %0d: sample %0d got %b, expected %b",
                                     f.data, f.div, bad_k, bad_act,
                                     exp_bit(f.data, bad_k, f.div));
                        end
                    end
                    mon_busy = 1'b0;
                end
            end
            prev = tx;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        bit          seen;
        int          n;
        memread  = 1'b0;
        memwrite = 1'b0;
        memaddr  = '0;
        memwdata = '0;
        cur_div  = CLK_DIV;
        rst      = 1'b1;
        #1 rst   = 1'b0;
        #1;
        check("reset_tx", 32'(tx), 32'h1);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        bus_rd(1, d); check("reset_status", d, 32'h2);
        bus_rd(2, d); check("reset_divisor", d, CLK_DIV);

        // Single frame, busy during the frame.
        push(8'h55);
        repeat (10) @(posedge clk);
        #1;
        bus_rd(1, d); check("busy_midframe", 32'(d[2]), 32'h1);
        wait_idle();
        bus_rd(1, d); check("status_after_single", d, 32'h2);

        // Back-to-back frames with no idle gap.
        start_cyc.delete();
        push(8'hA3);
        push(8'h0F);
        wait_idle();
        check("b2b_frame_count", start_cyc.size(), 2);
        if (start_cyc.size() == 2) check("b2b_gap", start_cyc[1] - start_cyc[0], 40);
        bus_rd(1, d); check("status_after_b2b", d, 32'h2);

        // Write-to-start latency, then reset during data bit 3 with a byte still queued.
        push(8'h52);
        check("latency_n1_idle", 32'(tx), 32'h1);
        @(posedge clk);
        #1;
        check("latency_n2_start", 32'(tx), 32'h0);
        push(8'h33);
        repeat (16) @(posedge clk);
        #1;
        check("data_bit3_level", 32'(tx), 32'h0);
        rst = 1'b0;
        #1;
        check("reset_async_tx", 32'(tx), 32'h1);
        exp_q.delete();
        cur_div = CLK_DIV;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        bus_rd(1, d); check("status_after_reset", d, 32'h2);
        repeat (60) @(posedge clk);
        #1;
        bus_rd(1, d); check("status_still_empty", d, 32'h2);

        // Divisor 0 is stored as 1: 10-cycle frame.
        bus_wr(2, 32'h0);
        bus_rd(2, d); check("divisor_zero_as_one", d, 32'h1);
        push(8'hC9);
        wait_idle();

        // Simultaneous read and write: read data shows the pre-edge value.
        memaddr  = reg_addr(2);
        memwdata = 32'hABCD_0007;
        memread  = 1'b1;
        memwrite = 1'b1;
        #1;
        check("rw_same_cycle_old", memrdata, 32'h1);
        @(posedge clk);
        #1;
        memwrite = 1'b0;
        cur_div  = 7;
        check("rw_same_cycle_new", memrdata, 32'h7);
        memread = 1'b0;

        // Divisor change mid-frame only affects the following frame.
        bus_wr(2, 32'h2);
        push(8'h6B);
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (mon_busy) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        check("frame_started", 32'(seen), 32'h1);
        bus_wr(2, 32'h3);
        push(8'h94);
        wait_idle();

        // Unmapped offset, write-only TXDATA, outside address, read strobe low.
        bus_rd(3, d); check("offset3_read", d, 32'h0);
        bus_rd(0, d); check("txdata_read", d, 32'h0);
        memaddr = BASE + 32'h10;
        memread = 1'b1;
        #1;
        check("outside_sel", 32'(sel), 32'h0);
        check("outside_rdata", memrdata, 32'h0);
        memaddr = reg_addr(2);
        memread = 1'b0;
        #1;
        check("inside_sel", 32'(sel), 32'h1);
        check("no_read_strobe", memrdata, 32'h0);
        @(posedge clk);
        #1;

        // Randomized traffic at random divisors.
        for (int p = 0; p < 4; p++) begin
            bus_wr(2, $urandom_range(0, 5));
            bus_rd(2, d); check("divisor_readback", d, cur_div);
            n = $urandom_range(6, 14);
            for (int i = 0; i < n; i++) begin
                for (int w = 0; w < 2000 && exp_q.size() >= DEPTH; w++) begin
                    @(posedge clk);
                    #1;
                end
                push(8'($urandom));
                repeat ($urandom_range(0, 3)) begin
                    if ($urandom_range(0, 1) == 1) begin
                        bus_rd(3, d); check("rand_offset3_read", d, 32'h0);
                    end else begin
                        bus_rd(0, d); check("rand_txdata_read", d, 32'h0);
                    end
                end
            end
            wait_idle();
            bus_rd(1, d); check("rand_status_idle", d, 32'h2);
        end

        // Overflow with the serializer stalled by a very long bit period.
        bus_wr(2, 32'hFFFF);
        push(8'h11);
        for (int i = 0; i < 9; i++) bus_wr(0, 32'($urandom_range(0, 255)));
        bus_rd(1, d); check("overflow_status", d, 32'h8D);
        bus_wr(1, $urandom);
        bus_rd(1, d); check("overflow_cleared", d, 32'h85);
        do_reset();
        bus_rd(1, d); check("status_after_ovf_reset", d, 32'h2);
        bus_rd(2, d); check("divisor_after_reset", d, CLK_DIV);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mmio_uart_tx.md
MMIO_UART_TX -- requirements
Module: mmio_uart_tx

Interface
REQ-001 Parameter WIDTH, default 32, data bus width; matches the core data width.
REQ-002 Parameter ADDR_WIDTH, default 32, address bus width.
REQ-003 Parameter BASE_ADDR, default 32'hFFFF_FF00, block base address; bits [3:0] SHALL be 0.
REQ-004 Parameter CLK_DIV, default 16, reset value of the bit-period divisor.
REQ-005 Parameter FIFO_DEPTH, default 8, TX FIFO entries; power of two, 2..16.
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 rst  input  1  asynchronous, active-low reset.
REQ-008 memread_i  input  1  core read strobe for the current cycle.
REQ-009 memwrite_i  input  1  core write strobe for the current cycle.
REQ-010 memaddr_i  input  ADDR_WIDTH  core byte address.
REQ-011 memwdata_i  input  WIDTH  core write data.
REQ-012 memrdata_o  output  WIDTH  register read data, combinational.
REQ-013 sel_o  output  1  combinational address hit, for the system read-data mux.
REQ-014 tx_o  output  1  serial line, idle high.

Function
REQ-015 Hit: sel_o = 1 when memaddr_i[ADDR_WIDTH-1:4] == BASE_ADDR[ADDR_WIDTH-1:4]; register offset = memaddr_i[3:2]; memaddr_i[1:0] ignored.
REQ-016 Offset 0 TXDATA (write-only): write pushes memwdata_i[7:0] into the FIFO; reads return 0.
REQ-017 Offset 1 STATUS (read): bit0 full, bit1 empty, bit2 busy (FSM not IDLE), bit3 overflow, bits[8:4] FIFO count; other bits 0; any write clears overflow.
REQ-018 Offset 2 DIVISOR (read/write): 16 bits in [15:0]; upper read bits 0; a written value of 0 is stored as 1.
REQ-019 Offset 3: reads return 0, writes ignored; memrdata_o = 0 whenever sel_o = 0 or memread_i = 0.
REQ-020 FIFO push/pop pointers wrap modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH.
REQ-021 Push while full with no pop in the same cycle: data dropped, overflow set (sticky), count unchanged.
REQ-022 Push and pop in the same cycle: the push is evaluated after the pop, so it is accepted even when full; count unchanged.
REQ-023 FSM states: IDLE, START, DATA, STOP; tx_o = 1 in IDLE and STOP, 0 in START, current data bit in DATA.
REQ-024 IDLE with FIFO non-empty: pop on that edge, latch byte and divisor, enter START.
REQ-025 Each of START, each DATA bit and STOP lasts exactly divisor cycles, counted by a bit-period counter.
REQ-026 DATA sends 8 bits LSB first, counted by a 3-bit bit index.
REQ-027 End of STOP: if FIFO non-empty, pop and go directly to START (no idle gap); else go to IDLE.
REQ-028 A DIVISOR write mid-frame does not affect the current frame; it takes effect at the next frame latch.
REQ-029 Latency: TXDATA write in cycle N into an empty FIFO with FSM IDLE gives tx_o = 0 from cycle N+2.
REQ-030 memread_i and memwrite_i both high: the write takes effect; read data reflects pre-edge state.

Reset
REQ-031 On rst = 0, immediately and asynchronously: tx_o = 1, FSM IDLE, FIFO empty (count 0, pointers 0), overflow 0, DIVISOR = CLK_DIV, counters 0.
REQ-032 Reset asserted mid-frame aborts the frame and discards FIFO contents; tx_o returns high without waiting for a clock edge.
REQ-033 After rst deasserts, first push accepted on the first rising edge.

Verification
REQ-034 CLK_DIV=4; write TXDATA 0x55 -> tx_o 0 for 4 cycles, then 1,0,1,0,1,0,1,0 at 4 cycles each, then 1 for 4 cycles; frame is 40 cycles; busy=1 throughout.
REQ-035 Write 0xA3 and 0x0F back-to-back -> two 40-cycle frames with no idle cycle between; STATUS reads empty=1, busy=0 afterwards.
REQ-036 FIFO_DEPTH=8, FSM stalled by DIVISOR=0xFFFF; 10 writes -> STATUS full=1, count=8 (one byte already popped), overflow=1; STATUS write clears overflow.
REQ-037 Write DIVISOR 0 -> read DIVISOR returns 1; next frame is 10 cycles long.
REQ-038 Reset pulse during DATA bit 3 -> tx_o = 1 at once; STATUS = 0x2 (empty); no further frames.
REQ-039 Read offset 3 and an address outside the block -> memrdata_o = 0; sel_o = 0 for the outside address.
